hex_display_master: RTL and testbench
=====================================

Name: hex_display_master

Overview:
- Avalon-MM write initiator that drives a bank of 7-bit HEX PIO output slaves, one slave per seven-segment digit.
- On `start`, latches a packed hex value and converts each nibble to a segment code.
- Issues one single-word write per digit, LSD first, honouring `avm_waitrequest`.
- Sits between application logic and the system interconnect, replacing software writes to the HEX PIOs.

Parameters:
- NUM_DIGITS, 6, number of HEX digits/slaves driven (1..8).
- ADDR_W, 16, width of `avm_address`.
- BASE_ADDR, 16'h0000, byte address of the digit-0 slave's data register.
- STRIDE, 16, byte distance between consecutive digit slaves (each slave spans 4 words).
- SEG_ACTIVE_LOW, 1, 1: segment on = 0 (DE2 HEX); 0: segment on = 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- value  in  4*NUM_DIGITS  packed nibbles; bits [3:0] = digit 0.
- blank_lz  in  1  1: blank leading zeros; latched with value.
- avm_address  out  ADDR_W  BASE_ADDR + digit*STRIDE.
- avm_chipselect  out  1  high during a write.
- avm_write_n  out  1  active-low write strobe.
- avm_writedata  out  7  segment code; bit0=a ... bit6=g.
- avm_waitrequest  in  1  slave stall; transfer completes on a cycle where it is 0.
- busy  out  1  high from the cycle after accepted start until DONE exits.
- done  out  1  one-cycle pulse after the last write completes.

Behaviour:
- Clock and reset: single clock `clk`; `reset_n` is synchronous and active-low, sampled on the rising edge of `clk`.
- Reset values: state=IDLE, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, busy=0, done=0, digit counter=0.
- All outputs are registered.
- FSM states:
  - IDLE: if start=1, latch value and blank_lz, digit=0, go to WRITE. Otherwise hold.
  - WRITE: chipselect=1, write_n=0, address/writedata for the current digit, all held stable while avm_waitrequest=1.
    - Transfer completes on an edge where waitrequest=0.
    - If digit==NUM_DIGITS-1, go to DONE.
    - Else increment digit and stay in WRITE, giving back-to-back writes with no idle cycle. Address and data update on the same edge.
  - DONE: chipselect=0, write_n=1, done=1 for exactly this cycle; next state IDLE.
- Throughput: with waitrequest tied 0, start at cycle 0 gives writes at cycles 1..NUM_DIGITS and done at cycle NUM_DIGITS+1.
- Busy: high in WRITE and DONE.
- Start while busy: ignored, not queued.
- Input changes: value/blank_lz changes after acceptance have no effect on the current sequence.
- Segment map (active-high codes for 0..F): 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - With SEG_ACTIVE_LOW=1, the code is bitwise inverted.
- Blank code: all segments off (7F active-low, 00 active-high).
- Leading-zero blanking (blank_lz=1):
  - A digit is blanked iff its nibble and all higher nibbles are zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blanked digits are still written.
- Address arithmetic: computed modulo 2^ADDR_W; no overflow flag.
- Reset mid-transfer: on the reset edge the FSM returns to IDLE and the strobes deassert the next cycle. The partial sequence is abandoned and no done pulse is issued.
- waitrequest outside WRITE is ignored.

Test Plan:
- Reset 3 cycles with waitrequest=0 -> all outputs at reset values; busy=0.
- value=24'h012345, blank_lz=0, waitrequest=0, default params -> 6 consecutive writes:
  - addr 0000/data 12 (5), 0010/19 (4), 0020/30 (3), 0030/24 (2), 0040/79 (1), 0050/40 (0).
  - done pulses 1 cycle later, at cycle 7.
- value=24'h0000A0, blank_lz=1 -> data sequence 40,08,7F,7F,7F,7F; value=0 with blank_lz=1 -> 40 then five 7F.
- Same as the first write scenario with waitrequest=1 for 3 cycles during digit 2 -> addr 0020/data 30 held 4 cycles; total 9 write-phase cycles; no duplicate or skipped digit.
- start pulsed again during digit 3 with a different value -> ignored; original 6 codes written; one done.
- reset_n=0 during digit 2 -> next cycle chipselect=0, write_n=1, state IDLE, no done; a fresh start then runs a full sequence from addr 0000.

Source files
------------

// File: rtl/hex_display_master.sv
//==============================================================================
// Module      : hex_display_master
// Description : Avalon-MM write initiator that converts a packed hex value to
//               seven-segment codes and writes one code per HEX PIO slave.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module hex_display_master #(
    parameter int                NUM_DIGITS     = 6,
    parameter int                ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                STRIDE         = 16,
    parameter bit                SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    output logic [ADDR_W-1:0]       avm_address,
    output logic                    avm_chipselect,
    output logic                    avm_write_n,
    output logic [6:0]              avm_writedata,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic                    done
);

    localparam int                CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int                VAL_W      = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0]  LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(STRIDE);
    localparam logic [6:0]        POL_MASK   = {7{SEG_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Active-high map then polarity flip; blank means all segments off.
    function automatic logic [6:0] seg_code(input logic [3:0] nib, input logic blank);
        logic [6:0] on;
        unique case (nib)
            4'h0: on = 7'h3F;
            4'h1: on = 7'h06;
            4'h2: on = 7'h5B;
            4'h3: on = 7'h4F;
            4'h4: on = 7'h66;
            4'h5: on = 7'h6D;
            4'h6: on = 7'h7D;
            4'h7: on = 7'h07;
            4'h8: on = 7'h7F;
            4'h9: on = 7'h6F;
            4'hA: on = 7'h77;
            4'hB: on = 7'h7C;
            4'hC: on = 7'h39;
            4'hD: on = 7'h5E;
            4'hE: on = 7'h79;
            default: on = 7'h71;
        endcase
        if (blank) begin
            on = 7'h00;
        end
        return on ^ POL_MASK;
    endfunction

    state_t            state_q;
    logic [CNT_W-1:0]  digit_q;
    logic [3:0]        nib_q   [NUM_DIGITS];
    logic              blank_q [NUM_DIGITS];
    logic [ADDR_W-1:0] addr_q;
    logic [6:0]        data_q;
    logic              cs_q;
    logic              write_n_q;
    logic              busy_q;
    logic              done_q;

    logic [NUM_DIGITS-1:0] w_blank_in;
    logic [CNT_W-1:0]      digit_d;
    logic [6:0]            code_d;

    // A digit blanks only when it and every more-significant nibble is zero.
    assign w_blank_in[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
            assign w_blank_in[gi] = blank_lz & ~(|value[VAL_W-1:4*gi]);
        end
    endgenerate

    assign digit_d = digit_q + CNT_W'(1);
    assign code_d  = seg_code(nib_q[digit_d], blank_q[digit_d]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            digit_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nib_q[i]   <= 4'h0;
                blank_q[i] <= 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            nib_q[i]   <= value[4*i +: 4];
                            blank_q[i] <= w_blank_in[i];
                        end
                        digit_q   <= '0;
                        addr_q    <= BASE_ADDR;
                        data_q    <= seg_code(value[3:0], 1'b0);
                        cs_q      <= 1'b1;
                        write_n_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!avm_waitrequest) begin
                        if (digit_q == LAST_DIGIT) begin
                            cs_q      <= 1'b0;
                            write_n_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            // Next digit's address and code land on the same edge.
                            digit_q <= digit_d;
                            addr_q  <= addr_q + STRIDE_A;
                            data_q  <= code_d;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    cs_q      <= 1'b0;
                    write_n_q <= 1'b1;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = data_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_master.sv
//==============================================================================
// Module      : tb_hex_display_master
// Description : Self-checking bench for hex_display_master with a behavioural
//               reference model, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hex_display_master;

    localparam int          N      = 6;
    localparam int          AW     = 16;
    localparam int          STRIDE = 16;
    localparam logic [15:0] BASE   = 16'h0000;

    logic            clk      = 1'b0;
    logic            reset_n  = 1'b0;
    logic            start    = 1'b0;
    logic [4*N-1:0]  value    = '0;
    logic            blank_lz = 1'b0;
    logic            waitreq  = 1'b0;
    logic [AW-1:0]   avm_address;
    logic            avm_chipselect;
    logic            avm_write_n;
    logic [6:0]      avm_writedata;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    hex_display_master #(
        .NUM_DIGITS(N), .ADDR_W(AW), .BASE_ADDR(BASE), .STRIDE(STRIDE), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .value(value), .blank_lz(blank_lz),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_waitrequest(waitreq), .busy(busy), .done(done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sequence of codes per accepted request, advanced by completions.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [6:0] code_of(input logic [4*N-1:0] v, input bit blz, input int i);
        logic [4*N-1:0] up;
        up = v >> (4 * i);
        if (blz && i != 0 && up == 0) return 7'h7F;
        return ~seg_tab[up[3:0]];
    endfunction

    int         m_phase = 0;   // 0 idle, 1 writing, 2 done pulse
    int         m_idx   = 0;
    bit         m_known = 1'b0;
    bit         m_fresh = 1'b0;
    logic [6:0] m_codes [N];

    always @(posedge clk) begin
        if (!reset_n) begin
            m_known <= 1'b1;
            m_fresh <= 1'b1;
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (start) begin
                for (int i = 0; i < N; i++) m_codes[i] <= code_of(value, blank_lz, i);
                m_idx   <= 0;
                m_phase <= 1;
                m_fresh <= 1'b0;
            end
        end else if (m_phase == 1) begin
            if (!waitreq) begin
                if (m_idx == N - 1) m_phase <= 2;
                else m_idx <= m_idx + 1;
            end
        end else begin
            m_phase <= 0;
        end
    end

    logic [22:0] cap_q[$];

    always @(negedge clk) begin
        if (m_known) begin
            check("chipselect", 32'(avm_chipselect), 32'(m_phase == 1));
            check("write_n", 32'(avm_write_n), 32'(m_phase != 1));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("done", 32'(done), 32'(m_phase == 2));
            if (m_phase == 1) begin
                check("address", 32'(avm_address), 32'(16'(BASE + m_idx * STRIDE)));
                check("writedata", 32'(avm_writedata), 32'(m_codes[m_idx]));
            end else if (m_fresh) begin
                check("reset address", 32'(avm_address), 32'h0);
                check("reset writedata", 32'(avm_writedata), 32'h0);
            end
        end
        if (reset_n && avm_chipselect === 1'b1 && avm_write_n === 1'b0 && waitreq === 1'b0)
            cap_q.push_back({avm_address, avm_writedata});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one request; cycle c is the cycle after edge c, start is sampled at edge 1.
    task automatic run_seq(input logic [4*N-1:0] v, input bit blz, input int stall_from,
                           input int stall_len, input int restart_at, input int reset_at,
                           input int max_cyc, output int done_cyc, output int n_done,
                           output int cs_cycles);
        int cyc;
        cap_q.delete();
        done_cyc  = -1;
        n_done    = 0;
        cs_cycles = 0;
        value     = v;
        blank_lz  = blz;
        start     = 1'b1;
        waitreq   = 1'b0;
        cyc       = 0;
        while (cyc < max_cyc && done_cyc < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            start   = (cyc == restart_at);
            if (start) begin
                value    = ~v;
                blank_lz = ~blz;
            end
            reset_n = !(cyc == reset_at);
            waitreq = (cyc >= stall_from && cyc < stall_from + stall_len);
            @(negedge clk);
            if (avm_chipselect === 1'b1) cs_cycles++;
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        start   = 1'b0;
        reset_n = 1'b1;
        waitreq = 1'b0;
        step();
        step();
    endtask

    task automatic check_caps(input string name, input logic [6:0] exp [N]);
        for (int i = 0; i < N; i++) begin
            if (i < cap_q.size()) begin
                check({name, " addr"}, 32'(cap_q[i][22:7]), 32'(i * STRIDE));
                check({name, " data"}, 32'(cap_q[i][6:0]), 32'(exp[i]));
            end
        end
    endtask

    logic [6:0] exp_s1  [N] = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    logic [6:0] exp_a0  [N] = '{7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] exp_zer [N] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    initial begin
        int dc, nd, csc;
        reset_n = 1'b0;
        waitreq = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("reset busy", 32'(busy), 32'h0);
        check("reset chipselect", 32'(avm_chipselect), 32'h0);
        check("reset write_n", 32'(avm_write_n), 32'h1);
        check("reset done", 32'(done), 32'h0);
        step();
        reset_n = 1'b1;
        step();

        run_seq(24'h012345, 1'b0, 100, 0, -1, -1, 30, dc, nd, csc);
        check("basic done cycle", 32'(dc), 32'd7);
        check("basic write count", 32'(cap_q.size()), 32'd6);
        check("basic write cycles", 32'(csc), 32'd6);
        check_caps("basic", exp_s1);

        run_seq(24'h0000A0, 1'b1, 100, 0, -1, -1, 30, dc, nd, csc);
        check("lz A0 write count", 32'(cap_q.size()), 32'd6);
        check_caps("lz A0", exp_a0);

        run_seq(24'h000000, 1'b1, 100, 0, -1, -1, 30, dc, nd, csc);
        check("lz zero write count", 32'(cap_q.size()), 32'd6);
        check_caps("lz zero", exp_zer);

        run_seq(24'h012345, 1'b0, 3, 3, -1, -1, 30, dc, nd, csc);
        check("stall done cycle", 32'(dc), 32'd10);
        check("stall write cycles", 32'(csc), 32'd9);
        check("stall write count", 32'(cap_q.size()), 32'd6);
        check_caps("stall", exp_s1);

        run_seq(24'h012345, 1'b0, 100, 0, 4, -1, 30, dc, nd, csc);
        check("restart done cycle", 32'(dc), 32'd7);
        check("restart write count", 32'(cap_q.size()), 32'd6);
        check_caps("restart", exp_s1);

        run_seq(24'h012345, 1'b0, 100, 0, -1, 3, 10, dc, nd, csc);
        check("reset-mid done count", 32'(nd), 32'd0);
        check("reset-mid write count", 32'(cap_q.size()), 32'd2);

        run_seq(24'h012345, 1'b0, 100, 0, -1, -1, 30, dc, nd, csc);
        check("after reset done cycle", 32'(dc), 32'd7);
        check("after reset write count", 32'(cap_q.size()), 32'd6);
        check_caps("after reset", exp_s1);

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int c = 0; c < 1500; c++) begin
            value    = 24'($urandom >> $urandom_range(8, 31));
            blank_lz = 1'($urandom_range(0, 1));
            start    = ($urandom_range(0, 5) == 0);
            waitreq  = ($urandom_range(0, 2) == 0);
            reset_n  = ($urandom_range(0, 99) != 0);
            step();
        end
        start   = 1'b0;
        reset_n = 1'b1;
        waitreq = 1'b0;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
